// File: rtl/mdu_unit_if.sv
// Operand/command/result bundle between the E stage and the multiply/divide unit.
// The E stage drives operands and commands; the unit returns busy and the HI/LO read port.
interface mdu_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  md_op;
  logic        start;
  logic        hi_lo_sel;
  logic        busy;
  logic [31:0] md_out;

  modport master (
    output a, b, md_op, start, hi_lo_sel,
    input  busy, md_out
  );

  modport slave (
    input  a, b, md_op, start, hi_lo_sel,
    output busy, md_out
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO, MTHI/MTLO writes and MFHI/MFLO mux.
// The result is computed at acceptance and held in tmp registers until the busy countdown ends.
module mdu_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic         clk,
  input logic         reset_n,
  mdu_unit_if.slave   md
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] tmp_hi_q, tmp_hi_d;
  logic [31:0] tmp_lo_q, tmp_lo_d;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;
  logic               div_ovf;
  logic               div_zero;

  assign prod_s   = 64'($signed(md.a)) * 64'($signed(md.b));
  assign prod_u   = {32'd0, md.a} * {32'd0, md.b};
  assign div_zero = (md.b == 32'd0);
  // Most-negative / -1 overflows the signed quotient; wrap it instead of relying on the operator.
  assign div_ovf  = (md.a == 32'h8000_0000) && (md.b == 32'hFFFF_FFFF);

  always_comb begin
    quot_s = 32'd0;
    rem_s  = 32'd0;
    quot_u = 32'd0;
    rem_u  = 32'd0;
    if (div_ovf) begin
      quot_s = 32'h8000_0000;
      rem_s  = 32'd0;
    end else if (!div_zero) begin
      quot_s = $signed(md.a) / $signed(md.b);
      rem_s  = $signed(md.a) % $signed(md.b);
    end
    if (!div_zero) begin
      quot_u = md.a / md.b;
      rem_u  = md.a % md.b;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    case (state_q)
      IDLE: begin
        if (md.start) begin
          case (md.md_op)
            OP_MULT: begin
              {tmp_hi_d, tmp_lo_d} = prod_s;
              cnt_d   = 4'(MUL_CYCLES);
              state_d = RUN;
            end
            OP_MULTU: begin
              {tmp_hi_d, tmp_lo_d} = prod_u;
              cnt_d   = 4'(MUL_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              // Divide-by-zero still runs the full latency but commits the old HI/LO.
              if (div_zero) begin
                tmp_hi_d = hi_q;
                tmp_lo_d = lo_q;
              end else if (md.md_op == OP_DIV) begin
                tmp_hi_d = rem_s;
                tmp_lo_d = quot_s;
              end else begin
                tmp_hi_d = rem_u;
                tmp_lo_d = quot_u;
              end
              cnt_d   = 4'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = md.a;
            OP_MTLO: lo_d = md.a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          hi_d    = tmp_hi_q;
          lo_d    = tmp_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
    end
  end

  assign md.busy   = (state_q == RUN);
  assign md.md_out = md.hi_lo_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, corner-case sequences
// and random operations checked against an arithmetic HI/LO model.
module tb_mdu_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic [31:0] m_hi, m_lo;

  mdu_unit_if mif ();

  mdu_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    mif.hi_lo_sel = 1'b1;
    #1;
    check32({name, ".hi"}, mif.md_out, eh);
    mif.hi_lo_sel = 1'b0;
    #1;
    check32({name, ".lo"}, mif.md_out, el);
  endtask

  function automatic int exp_cycles_of(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return MUL_N;
    if (op == 4'd3 || op == 4'd4) return DIV_N;
    return 0;
  endfunction

  // Reference model: plain 64-bit arithmetic on magnitudes and signs.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd3: if (b != 0) begin
        q = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
        if ((sa < 0) != (sb < 0)) q = -q;
        r = sa - q * sb;
        p = 64'(q); m_lo = p[31:0];
        p = 64'(r); m_hi = p[31:0];
      end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      4'd5: m_hi = a;
      4'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue op at the next edge; optionally try a second command on the following edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic intr, input logic [3:0] iop, input logic [31:0] ia,
                        output int cycles);
    @(negedge clk);
    mif.md_op = op; mif.a = a; mif.b = b; mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    cycles = 0;
    if (intr) begin
      mif.md_op = iop; mif.a = ia; mif.b = 32'd3; mif.start = 1'b1;
    end
    while (mif.busy && cycles < 40) begin
      cycles++;
      @(negedge clk);
      mif.start = 1'b0;
    end
    mif.start = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [3:0]  rop;
    logic [31:0] ra, rb;
    checks = 0; failures = 0;
    mif.a = 0; mif.b = 0; mif.md_op = 0; mif.start = 0; mif.hi_lo_sel = 0;

    vecs[0] = '{4'd1, 32'hFFFF_FFFD, 32'd4,          MUL_N, 32'hFFFF_FFFF, 32'hFFFF_FFF4};
    vecs[1] = '{4'd2, 32'hFFFF_FFFF, 32'd2,          MUL_N, 32'h0000_0001, 32'hFFFF_FFFE};
    vecs[2] = '{4'd3, 32'hFFFF_FFF9, 32'd2,          DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{4'd4, 32'd7,         32'd0,          DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  DIV_N, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{4'd5, 32'h1234_5678, 32'd9,          0,     32'h1234_5678, 32'h8000_0000};
    vecs[6] = '{4'd0, 32'hDEAD_BEEF, 32'd1,          0,     32'h1234_5678, 32'h8000_0000};
    vecs[7] = '{4'd9, 32'hDEAD_BEEF, 32'd1,          0,     32'h1234_5678, 32'h8000_0000};

    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check32("reset.busy", 32'(mif.busy), 32'd0);
    check_hilo("reset", 32'd0, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 4'd0, 32'd0, cyc);
      check32($sformatf("vec%0d.cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      check_hilo($sformatf("vec%0d", i), vecs[i].exp_hi, vecs[i].exp_lo);
      $display("vec %0d op=%0d a=%08h b=%08h cycles=%0d", i, vecs[i].op, vecs[i].a, vecs[i].b, cyc);
    end
    m_hi = 32'h1234_5678; m_lo = 32'h8000_0000;

    // MTLO while busy is dropped; LO keeps the product.
    run_op(4'd1, 32'd6, 32'd7, 1'b1, 4'd6, 32'hAAAA_5555, cyc);
    check32("mtlo_busy.cycles", 32'(cyc), 32'(MUL_N));
    check_hilo("mtlo_busy", 32'd0, 32'd42);
    $display("seq mtlo-during-busy cycles=%0d", cyc);

    // Second MULT during RUN: ignored, busy not extended.
    run_op(4'd2, 32'd1000, 32'd3, 1'b1, 4'd2, 32'd55, cyc);
    check32("mult_twice.cycles", 32'(cyc), 32'(MUL_N));
    check_hilo("mult_twice", 32'd0, 32'd3000);
    $display("seq mult-during-run cycles=%0d", cyc);

    // Reset in cycle 3 of a DIV aborts it with no late commit.
    @(negedge clk);
    mif.md_op = 4'd3; mif.a = 32'd100; mif.b = 32'd7; mif.start = 1'b1;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (2) @(negedge clk);
    check32("abort.busy_before", 32'(mif.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check32("abort.busy", 32'(mif.busy), 32'd0);
    check_hilo("abort", 32'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (DIV_N + 3) @(negedge clk);
    check32("abort.late_busy", 32'(mif.busy), 32'd0);
    check_hilo("abort.late", 32'd0, 32'd0);
    $display("seq reset-mid-div done");
    m_hi = 32'd0; m_lo = 32'd0;

    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
      run_op(rop, ra, rb, 1'b0, 4'd0, 32'd0, cyc);
      model(rop, ra, rb);
      check32($sformatf("rnd%0d.cycles", i), 32'(cyc), 32'(exp_cycles_of(rop)));
      check_hilo($sformatf("rnd%0d", i), m_hi, m_lo);
      $display("rnd %0d op=%0d a=%08h b=%08h hi=%08h lo=%08h", i, rop, ra, rb, m_hi, m_lo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
